// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage. Owns the fetch PC, the instruction
//               memory request handshake and the IF/ID pipeline register.
//               A one-entry fetch buffer and a three-state request FSM
//               absorb variable-latency instruction memory.
// Ports       : Clk, Reset (sync, active-high)
//               PC_Write, IF_ID_Write, IF_Flush, jal_Control, BranchTarget
//                   - control from hazard detection
//               IMemReq/IMemAddr out, IMemAck/IMemRdata in - memory handshake
//               PC_IF, Instruction_ID, PCPlus4_ID, Valid_ID, Link_ID
//                   - fetch PC and IF/ID contents
//               FetchStall - IF/ID took a bubble because memory did not ack
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PC_Write,
    input  logic        IF_ID_Write,
    input  logic        IF_Flush,
    input  logic        jal_Control,
    input  logic [31:0] BranchTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRdata,
    output logic [31:0] PC_IF,
    output logic [31:0] Instruction_ID,
    output logic [31:0] PCPlus4_ID,
    output logic        Valid_ID,
    output logic [31:0] Link_ID,
    output logic        FetchStall
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    // S_REQ : request outstanding at PC_IF
    // S_HOLD: word fetched into the buffer while the pipe was stalled
    // S_DROP: redirected while a request was outstanding; wait for the ack
    //         of the stale request before moving to the pending target
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fbuf_q, fbuf_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;
    logic [31:0] link_q, link_d;

    logic        stall;
    logic        redirect;
    logic        bubble;
    logic        advance;
    logic [31:0] adv_word;
    logic        fetch_stall;
    logic [31:0] pc_next;

    assign stall    = !PC_Write || !IF_ID_Write;
    assign redirect = IF_Flush;
    assign pc_next  = pc_q + c_PC_STEP;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fbuf_d      = fbuf_q;
        pend_d      = pend_q;
        instr_d     = instr_q;
        pcplus4_d   = pcplus4_q;
        valid_d     = valid_q;
        link_d      = link_q;
        bubble      = 1'b0;
        advance     = 1'b0;
        adv_word    = IMemRdata;
        fetch_stall = 1'b0;

        case (state_q)
            S_REQ: begin
                if (IMemAck) begin
                    if (redirect) begin
                        pc_d   = BranchTarget;
                        bubble = 1'b1;
                    end else if (!stall) begin
                        advance = 1'b1;
                    end else begin
                        fbuf_d  = IMemRdata;
                        state_d = S_HOLD;
                    end
                end else begin
                    if (redirect) begin
                        // The request is still in flight at the old address;
                        // its address must not move until it is acked.
                        pend_d  = BranchTarget;
                        bubble  = 1'b1;
                        state_d = S_DROP;
                    end else if (!stall) begin
                        bubble      = 1'b1;
                        fetch_stall = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = BranchTarget;
                    bubble  = 1'b1;
                    state_d = S_REQ;
                end else if (!stall) begin
                    advance  = 1'b1;
                    adv_word = fbuf_q;
                    state_d  = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pend_d = BranchTarget;
                end
                if (IF_ID_Write || redirect) begin
                    bubble = 1'b1;
                end
                if (IMemAck) begin
                    pc_d    = redirect ? BranchTarget : pend_q;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (bubble) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
        if (advance) begin
            instr_d   = adv_word;
            pcplus4_d = pc_next;
            valid_d   = 1'b1;
            pc_d      = pc_next;
        end

        // The jal sits in ID during the redirect, so its PC+4 is the link.
        if (redirect && jal_Control) begin
            link_d = pcplus4_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            fbuf_q    <= 32'd0;
            pend_q    <= 32'd0;
            instr_q   <= NOP_INSTR;
            pcplus4_q <= 32'd0;
            valid_q   <= 1'b0;
            link_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fbuf_q    <= fbuf_d;
            pend_q    <= pend_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
            link_q    <= link_d;
        end
    end

    assign IMemReq        = !Reset && (state_q != S_HOLD);
    assign IMemAddr       = pc_q;
    assign PC_IF          = pc_q;
    assign Instruction_ID = instr_q;
    assign PCPlus4_ID     = pcplus4_q;
    assign Valid_ID       = valid_q;
    assign Link_ID        = link_q;
    assign FetchStall     = !Reset && fetch_stall;

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Sits directly downstream of hazard detection. It consumes PC_Write, IF_ID_Write, IF_Flush and jal_Control, and produces the IF/ID contents that the ID stage and hazard detection read.
- Absorbs variable-latency instruction memory through a one-entry fetch buffer and a 3-state request FSM.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word injected as a bubble

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high
PC_Write  input  1  from hazard detection; 0 = hold PC
IF_ID_Write  input  1  from hazard detection; 0 = hold IF/ID
IF_Flush  input  1  from hazard detection; redirect to BranchTarget and squash fetch
jal_Control  input  1  from hazard detection; qualifies IF_Flush as a jal redirect
BranchTarget  input  32  redirect address, valid when IF_Flush=1
IMemReq  output  1  instruction-memory request
IMemAddr  output  32  request address (= PC_IF)
IMemAck  input  1  memory accepts request; IMemRdata valid this cycle
IMemRdata  input  32  fetched instruction
PC_IF  output  32  current fetch PC
Instruction_ID  output  32  IF/ID instruction
PCPlus4_ID  output  32  IF/ID PC+4
Valid_ID  output  1  IF/ID holds a real instruction
Link_ID  output  32  jal return address
FetchStall  output  1  combinational; IF/ID received a bubble because memory has not acked

Behaviour:
- Reset values (synchronous, Reset=1 at edge): PC_IF=RESET_PC, state=S_REQ, fetch buffer empty, Instruction_ID=NOP_INSTR, PCPlus4_ID=0, Valid_ID=0, Link_ID=0. IMemReq=0 while Reset=1. Reset overrides every other input, including mid-request; any late ack is ignored.
- Derived signals: stall = !PC_Write || !IF_ID_Write; redirect = IF_Flush. Redirect has priority over stall.
- IMemAddr is always PC_IF. Once IMemReq is high, PC_IF and IMemAddr must not change until IMemAck.
- S_REQ: IMemReq=1.
  - ack & redirect: discard IMemRdata; PC_IF<=BranchTarget; IF/ID<=bubble; stay S_REQ.
  - ack & !stall: IF/ID<={IMemRdata, PC_IF+4, Valid 1}; PC_IF<=PC_IF+4; stay S_REQ. Back-to-back fetch, one instruction per cycle with a zero-wait memory.
  - ack & stall: fetch buffer<=IMemRdata; IF/ID unchanged; PC_IF unchanged; go S_HOLD.
  - !ack & redirect: PendTarget<=BranchTarget; IF/ID<=bubble; go S_DROP.
  - !ack & !stall: IF/ID<=bubble (NOP_INSTR, PCPlus4_ID unchanged, Valid 0); FetchStall=1.
  - !ack & stall: hold everything.
- S_HOLD: IMemReq=0.
  - redirect: drop buffer; PC_IF<=BranchTarget; IF/ID<=bubble; go S_REQ.
  - !stall: IF/ID<={buffer, PC_IF+4, 1}; PC_IF<=PC_IF+4; go S_REQ.
  - stall: hold.
- S_DROP: IMemReq=1 at the old address.
  - Each further redirect overwrites PendTarget.
  - On ack: discard data; PC_IF<=PendTarget (or BranchTarget if redirect the same cycle); go S_REQ.
  - IF/ID loads a bubble whenever IF_ID_Write=1 or redirect.
- Link: on redirect & jal_Control, Link_ID<=PCPlus4_ID (the jal in ID); otherwise hold.
- PC arithmetic is modulo 2^32; PC_IF=32'hFFFF_FFFC wraps to 0. Bits [1:0] pass through unchecked.
- Redirect and stall in the same cycle: redirect wins, and IF/ID is overwritten with a bubble even with IF_ID_Write=0.

Test Plan:
- Reset, then IMemAck tied 1 with IMemRdata=PC-derived pattern → PC_IF sequence 0,4,8,12. From cycle 2, Instruction_ID follows the pattern with Valid_ID=1 and PCPlus4_ID=PC+4.
- Ack at PC=8, IF_ID_Write=PC_Write=0 for 3 cycles → S_HOLD, IMemReq=0, IF/ID holds the PC=4 instruction. On release, Instruction_ID=word@8, PCPlus4_ID=12, PC_IF=12.
- IMemAck low for 2 cycles at PC=16 with no stall → two bubbles (Valid_ID=0, FetchStall=1), IMemAddr stable at 16; ack on the 3rd cycle → word@16 loaded.
- Redirect (IF_Flush=1, BranchTarget=0x100) while a request to 0x20 is unacked → S_DROP. Ack after 2 cycles, data discarded, next IMemAddr=0x100, no Valid_ID=1 from 0x20.
- IF_Flush=1, jal_Control=1, PCPlus4_ID=0x44, BranchTarget=0x200 → Link_ID=0x44, PC_IF=0x200, IF/ID bubble.
- Reset asserted in S_HOLD with a buffer full → next cycle PC_IF=RESET_PC, Valid_ID=0, IMemReq=0 during reset, buffer contents never reach ID.
